// File: rtl/seq_shift_add_mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
//   mul_state_t : controller states IDLE -> RUN -> DONE
//   clog2()     : width of the step counter that has to hold WB-1
// No ports; imported by the multiplier top.

package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    // Smallest width w (at least 1) with 2**w >= value; enough to hold value-1.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/seq_shift_add_mul_if.sv
// Operand/result handshake bundle for the sequential multiplier.
//   in_valid/in_ready : operand handshake, carries a (WA bits) and b (WB bits)
//   out_valid/out_ready : result handshake, carries p (WA+WB bits)
// master : operand source and result consumer
// slave  : the multiplier

interface seq_shift_add_mul_if #(
    parameter int WA = 4,
    parameter int WB = 3
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WA-1:0]        a;
    logic [WB-1:0]        b;
    logic                 out_valid;
    logic                 out_ready;
    logic [WA+WB-1:0]     p;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, p
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, p
    );
endinterface

// File: rtl/seq_shift_add_mul_rca.sv
// Parametrised ripple-carry adder used for the per-step partial-product add.
//   a, b : N-bit addends
//   cin  : carry in
//   s    : N-bit sum
//   cout : carry out of the top bit

module rca_nbit #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);

    // One full adder per bit; the running carry is a scalar variable so the
    // chain stays a plain ripple without a self-referencing carry vector.
    always_comb begin
        logic carry;
        carry = cin;
        s     = '0;
        for (int i = 0; i < N; i++) begin
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/seq_shift_add_mul.sv
// Unsigned sequential shift-add multiplier, P = A*B, one WA-bit adder reused
// over WB RUN cycles.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : slave side of seq_shift_add_mul_if (in_valid/in_ready/a/b,
//           out_valid/out_ready/p)
// Optional build macro MUL_ZERO_SKIP_EN: a zero operand skips RUN and the
// result (p=0) is presented one clock after the accept edge.

module seq_shift_add_mul
    import mul_pkg::*;
#(
    parameter int WA = 4,
    parameter int WB = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    seq_shift_add_mul_if.slave  bus
);

    localparam int WP = WA + WB;
    localparam int CW = clog2(WB);

    mul_state_t      state_q, state_d;
    logic [WA-1:0]   mcand_q, mcand_d;
    logic [WA-1:0]   hi_q, hi_d;
    logic [WB-1:0]   lo_q, lo_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WP-1:0]   p_q, p_d;
    logic            out_valid_q, out_valid_d;

    logic [WA-1:0]   addend;
    logic [WA-1:0]   sum;
    logic            carry;

    // The multiplier LSB decides whether this step adds the multiplicand.
    assign addend = lo_q[0] ? mcand_q : '0;

    rca_nbit #(.N(WA)) u_rca (
        .a    (hi_q),
        .b    (addend),
        .cin  (1'b0),
        .s    (sum),
        .cout (carry)
    );

`ifdef MUL_ZERO_SKIP_EN
    logic zero_op;
    assign zero_op = (bus.a == '0) || (bus.b == '0);
`endif

    // Controller and shift register next state. In RUN the {carry,sum,lo}
    // word is shifted right by one, so the low product bits migrate into lo
    // as the consumed multiplier bits fall out. DONE spends one cycle copying
    // {hi,lo} into p before raising out_valid, giving the WB+1 latency.
    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        cnt_d       = cnt_q;
        p_d         = p_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    mcand_d = bus.a;
                    lo_d    = bus.b;
                    hi_d    = '0;
                    cnt_d   = CW'(WB - 1);
                    state_d = RUN;
`ifdef MUL_ZERO_SKIP_EN
                    // Clearing lo makes {hi,lo} read as zero in DONE.
                    if (zero_op) begin
                        lo_d    = '0;
                        state_d = DONE;
                    end
`endif
                end
            end

            RUN: begin
                {hi_d, lo_d} = {carry, sum, lo_q[WB-1:1]};
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            DONE: begin
                if (!out_valid_q) begin
                    p_d         = {hi_q, lo_q};
                    out_valid_d = 1'b1;
                end else if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset; reset discards any operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            cnt_q       <= '0;
            p_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            cnt_q       <= cnt_d;
            p_q         <= p_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Operands are only taken in IDLE, so in_ready is a pure state decode.
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.p         = p_q;

endmodule

// File: tb/tb_seq_shift_add_mul.sv
// Self-checking bench for seq_shift_add_mul: a 4x3 instance checked every
// cycle against a transaction-level timing model, plus an 8x8 instance with
// directed literal checks. Honours MUL_ZERO_SKIP_EN for zero-operand latency.

module tb_seq_shift_add_mul;

    localparam int WA = 4;
    localparam int WB = 3;
    localparam int WP = WA + WB;

`ifdef MUL_ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic clk;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    seq_shift_add_mul_if #(.WA(WA), .WB(WB)) bus4 ();
    seq_shift_add_mul_if #(.WA(8),  .WB(8))  bus8 ();

    seq_shift_add_mul #(.WA(WA), .WB(WB)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    seq_shift_add_mul #(.WA(8), .WB(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transaction model: an accepted operation is busy for a fixed number of
    // edges, then shows a*b until the consumer takes it.
    bit             mLive     = 1'b0;
    bit             mIdle     = 1'b1;
    bit             mOutValid = 1'b0;
    bit             mAccepted = 1'b0;
    int             mCount    = 0;
    logic [WP-1:0]  mPend     = '0;
    logic [WP-1:0]  mP        = '0;

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [WA-1:0] a,
                                 input logic [WB-1:0] b, input logic ordy);
        bus4.in_valid  = v;
        bus4.a         = a;
        bus4.b         = b;
        bus4.out_ready = ordy;
    endtask

    // Model update on each edge, compare on the following falling edge.
    initial begin
        logic sRst, sIv, sOrdy;
        logic [WA-1:0] sA;
        logic [WB-1:0] sB;
        forever begin
            @(posedge clk);
            sRst = rst_n; sIv = bus4.in_valid; sOrdy = bus4.out_ready;
            sA = bus4.a;  sB = bus4.b;
            mAccepted = 1'b0;
            if (!sRst) begin
                mLive = 1'b1; mIdle = 1'b1; mOutValid = 1'b0; mCount = 0; mP = '0;
            end else if (mIdle) begin
                if (sIv) begin
                    mIdle     = 1'b0;
                    mAccepted = 1'b1;
                    mPend     = WP'(sA) * WP'(sB);
                    mCount    = (SKIP && (sA == 0 || sB == 0)) ? 1 : WB + 1;
                end
            end else if (mCount > 0) begin
                mCount--;
                if (mCount == 0) begin
                    mOutValid = 1'b1;
                    mP        = mPend;
                end
            end else if (mOutValid && sOrdy) begin
                mOutValid = 1'b0;
                mIdle     = 1'b1;
            end
            @(negedge clk);
            if (mLive) begin
                checkOutput("in_ready",  32'(bus4.in_ready),  32'(mIdle));
                checkOutput("out_valid", 32'(bus4.out_valid), 32'(mOutValid));
                checkOutput("p",         32'(bus4.p),         32'(mP));
            end
        end
    end

    task automatic waitAccept();
        int n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!mAccepted && n < 50);
        checkOutput("acceptTimeout", 32'(mAccepted), 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        applyStimulus(1'b0, '0, '0, 1'b1);
        while (!mIdle && n < 50) begin
            @(posedge clk); #1; n++;
        end
        checkOutput("drainTimeout", 32'(mIdle), 32'd1);
    endtask

    // Directed op on the 4x3 instance: edges from accept to out_valid and p.
    task automatic measure4(input string name, input logic [WA-1:0] a,
                            input logic [WB-1:0] b, input int expP, input int expLat);
        int n = 0;
        drain();
        applyStimulus(1'b1, a, b, 1'b1);
        @(posedge clk); #1;
        applyStimulus(1'b0, WA'($urandom), WB'($urandom), 1'b1);
        do begin
            @(posedge clk); #1; n++;
        end while (!bus4.out_valid && n < 20);
        checkOutput({name, "_lat"}, 32'(n), 32'(expLat));
        checkOutput({name, "_p"},   32'(bus4.p), 32'(expP));
    endtask

    task automatic measure8(input string name, input logic [7:0] a,
                            input logic [7:0] b, input int expP, input int expLat);
        int n = 0;
        bus8.in_valid = 1'b1; bus8.a = a; bus8.b = b; bus8.out_ready = 1'b1;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0; bus8.a = 8'($urandom); bus8.b = 8'($urandom);
        do begin
            @(posedge clk); #1; n++;
        end while (!bus8.out_valid && n < 30);
        checkOutput({name, "_lat"}, 32'(n), 32'(expLat));
        checkOutput({name, "_p"},   32'(bus8.p), 32'(expP));
        repeat (2) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b1);
        bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_in_ready",  32'(bus4.in_ready),  32'd1);
        checkOutput("rst_out_valid", 32'(bus4.out_valid), 32'd0);
        checkOutput("rst_p",         32'(bus4.p),         32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] directed 15*7");
        measure4("mul15x7", 4'd15, 3'd7, 105, WB + 1);

        $display("[TB] backpressure 9*5");
        drain();
        applyStimulus(1'b1, 4'd9, 3'd5, 1'b0);
        @(posedge clk); #1;
        applyStimulus(1'b1, 4'd3, 3'd2, 1'b0);
        begin
            int n = 0;
            do begin
                @(posedge clk); #1; n++;
            end while (!bus4.out_valid && n < 20);
        end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checkOutput("bp_p",         32'(bus4.p),         32'd45);
            checkOutput("bp_out_valid", 32'(bus4.out_valid), 32'd1);
            checkOutput("bp_in_ready",  32'(bus4.in_ready),  32'd0);
        end
        applyStimulus(1'b0, '0, '0, 1'b1);

        $display("[TB] reset mid-run");
        drain();
        applyStimulus(1'b1, 4'd12, 3'd6, 1'b1);
        @(posedge clk); #1;
        applyStimulus(1'b0, '0, '0, 1'b1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        checkOutput("midrst_out_valid", 32'(bus4.out_valid), 32'd0);
        checkOutput("midrst_p",         32'(bus4.p),         32'd0);
        checkOutput("midrst_in_ready",  32'(bus4.in_ready),  32'd1);
        rst_n = 1'b1;
        measure4("mul3x3", 4'd3, 3'd3, 9, WB + 1);

        $display("[TB] zero operand");
        measure4("mul0x5", 4'd0, 3'd5, 0, SKIP ? 1 : WB + 1);

        $display("[TB] exhaustive back-to-back");
        drain();
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 8; b++) begin
                applyStimulus(1'b1, WA'(a), WB'(b), 1'b1);
                waitAccept();
            end
        end
        drain();

        $display("[TB] randomized traffic");
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            rst_n = ($urandom_range(0, 149) != 0);
            applyStimulus(1'($urandom), WA'($urandom), WB'($urandom),
                          ($urandom_range(0, 3) != 0));
        end
        rst_n = 1'b1;
        drain();

        $display("[TB] 8x8 instance");
        measure8("mul255x255", 8'd255, 8'd255, 16'hFE01, 9);
        measure8("mul128x2",   8'd128, 8'd2,   256,      9);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
